pc_fetch_unit: RTL and testbench

Program-counter and fetch-request stage sitting directly upstream of the hazard unit and the IF/ID latch. It holds the architectural PC, picks the next PC (sequential, jump, jump-register, taken branch) from the EX-stage redirect inputs, and advances only when the hazard unit grants `pc_enable`. A redirect seen while the PC is stalled is parked in a pending register and applied on the next enabled cycle. It also owns the sticky halt state that stops instruction fetch.

---
 rtl/pc_fetch_unit_if.sv | 31 +++
 rtl/pc_fetch_unit.sv | 105 ++++++++++
 tb/tb_pc_fetch_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: EX-stage redirect inputs, hazard/halt controls and the
// instruction-fetch outputs of the PC stage.
interface pc_fetch_unit_if;
    logic        pc_enable;
    logic [2:0]  pc_select;
    logic        z_fl;
    logic [31:0] ex_pc_plus4;
    logic [15:0] ex_imm16;
    logic [25:0] ex_jaddr;
    logic [31:0] ex_rdat1;
    logic        halt_in;
    logic [31:0] imemaddr;
    logic        imemREN;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        halt;

    // Driver side (pipeline control / testbench)
    modport master (
        output pc_enable, pc_select, z_fl, ex_pc_plus4, ex_imm16,
               ex_jaddr, ex_rdat1, halt_in,
        input  imemaddr, imemREN, pc_plus4, redirect, halt
    );

    // PC stage side
    modport slave (
        input  pc_enable, pc_select, z_fl, ex_pc_plus4, ex_imm16,
               ex_jaddr, ex_rdat1, halt_in,
        output imemaddr, imemREN, pc_plus4, redirect, halt
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch-request stage. Selects the next PC from the
// EX-stage redirect, parks redirects that arrive while stalled, and owns
// the sticky halt state that stops instruction fetch.
module pc_fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic           CLK,
    input  logic           nRST,
    pc_fetch_unit_if.slave bus
);

    localparam logic [2:0] SEL_JUMP  = 3'd1;
    localparam logic [2:0] SEL_JR    = 3'd2;
    localparam logic [2:0] SEL_BEQ   = 3'd3;
    localparam logic [2:0] SEL_BNE   = 3'd4;

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        taken;
    logic [31:0] live_target;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] pc_plus4;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = bus.ex_pc_plus4 + {{14{bus.ex_imm16[15]}}, bus.ex_imm16, 2'b00};
    assign jump_target   = {bus.ex_pc_plus4[31:28], bus.ex_jaddr, 2'b00};

    // Taken decision and live redirect target; selects 0 and 5-7 are NEXT
    always_comb begin
        taken       = 1'b0;
        live_target = branch_target;
        case (bus.pc_select)
            SEL_JUMP: begin
                taken       = 1'b1;
                live_target = jump_target;
            end
            SEL_JR: begin
                taken       = 1'b1;
                live_target = bus.ex_rdat1;
            end
            SEL_BEQ: taken = bus.z_fl;
            SEL_BNE: taken = ~bus.z_fl;
            default: taken = 1'b0;
        endcase
    end

    // Next-state: halt dominates, then enabled advance, then stall parking
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        case (state_q)
            RUN: begin
                if (bus.halt_in) begin
                    state_d = HALTED;
                end else if (bus.pc_enable) begin
                    if (taken)
                        pc_d = live_target;
                    else if (pend_valid_q)
                        pc_d = pend_target_q;
                    else
                        pc_d = pc_plus4;
                    pend_valid_d = 1'b0;
                end else if (taken) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = live_target;
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // State, PC and pending-redirect registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= RUN;
            pc_q          <= PC_INIT;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign bus.imemaddr = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.redirect = taken;
    assign bus.imemREN  = (state_q == RUN);
    assign bus.halt     = (state_q == HALTED);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
module tb_pc_fetch_unit;

    logic CLK;
    logic nRST;
    int   passed;
    int   total;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic en, input logic [2:0] sel, input logic [31:0] rdat);
        bus.pc_enable = en;
        bus.pc_select = sel;
        bus.ex_rdat1  = rdat;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        bus.pc_enable = 1'b0; bus.pc_select = 3'd0; bus.z_fl = 1'b0;
        bus.ex_pc_plus4 = '0; bus.ex_imm16 = '0; bus.ex_jaddr = '0;
        bus.ex_rdat1 = '0; bus.halt_in = 1'b0;
        #2;
        total++; if (bus.imemaddr !== 32'h0) $display("FAIL reset_pc got %h exp %h", bus.imemaddr, 32'h0); else passed++;
        total++; if (bus.imemREN !== 1'b1) $display("FAIL reset_ren got %b exp 1", bus.imemREN); else passed++;
        total++; if (bus.halt !== 1'b0) $display("FAIL reset_halt got %b exp 0", bus.halt); else passed++;
        total++; if (bus.pc_plus4 !== 32'h4) $display("FAIL reset_pcp4 got %h exp %h", bus.pc_plus4, 32'h4); else passed++;
        @(negedge CLK);
        nRST = 1'b1;
        drive(1'b1, 3'd0, '0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (bus.imemaddr !== 32'(4 * i)) $display("FAIL seq_pc%0d got %h exp %h", i, bus.imemaddr, 32'(4 * i));
            else passed++;
        end
        total++; if (bus.imemREN !== 1'b1 || bus.halt !== 1'b0) $display("FAIL seq_ctl got ren=%b halt=%b exp ren=1 halt=0", bus.imemREN, bus.halt); else passed++;
    endtask

    task automatic test_branch();
        // PC = 0xC here
        bus.pc_select = 3'd3; bus.z_fl = 1'b1; bus.ex_pc_plus4 = 32'h100; bus.ex_imm16 = 16'hFFFE;
        #1;
        total++; if (bus.redirect !== 1'b1) $display("FAIL beq_redirect got %b exp 1", bus.redirect); else passed++;
        tick();
        total++; if (bus.imemaddr !== 32'hF8) $display("FAIL beq_taken got %h exp %h", bus.imemaddr, 32'hF8); else passed++;
        bus.z_fl = 1'b0;
        #1;
        total++; if (bus.redirect !== 1'b0) $display("FAIL beq_nt_redirect got %b exp 0", bus.redirect); else passed++;
        tick();
        total++; if (bus.imemaddr !== 32'hFC) $display("FAIL beq_not_taken got %h exp %h", bus.imemaddr, 32'hFC); else passed++;
        bus.pc_select = 3'd4; bus.ex_imm16 = 16'h0004;
        tick();
        total++; if (bus.imemaddr !== 32'h110) $display("FAIL bne_taken got %h exp %h", bus.imemaddr, 32'h110); else passed++;
        bus.pc_select = 3'd6;
        #1;
        total++; if (bus.redirect !== 1'b0) $display("FAIL sel6_redirect got %b exp 0", bus.redirect); else passed++;
        tick();
        total++; if (bus.imemaddr !== 32'h114) $display("FAIL sel6_next got %h exp %h", bus.imemaddr, 32'h114); else passed++;
    endtask

    task automatic test_jump();
        bus.pc_select = 3'd1; bus.ex_pc_plus4 = 32'h1000_0040; bus.ex_jaddr = 26'h000_0010;
        tick();
        total++; if (bus.imemaddr !== 32'h1000_0040) $display("FAIL jump got %h exp %h", bus.imemaddr, 32'h1000_0040); else passed++;
        drive(1'b1, 3'd2, 32'h2000);
        tick();
        total++; if (bus.imemaddr !== 32'h2000) $display("FAIL jr got %h exp %h", bus.imemaddr, 32'h2000); else passed++;
    endtask

    task automatic test_pending();
        drive(1'b0, 3'd2, 32'h3000);
        tick();
        total++; if (bus.imemaddr !== 32'h2000) $display("FAIL stall1 got %h exp %h", bus.imemaddr, 32'h2000); else passed++;
        tick();
        total++; if (bus.imemaddr !== 32'h2000) $display("FAIL stall2 got %h exp %h", bus.imemaddr, 32'h2000); else passed++;
        drive(1'b1, 3'd0, '0);
        tick();
        total++; if (bus.imemaddr !== 32'h3000) $display("FAIL pend_apply got %h exp %h", bus.imemaddr, 32'h3000); else passed++;
        tick();
        total++; if (bus.imemaddr !== 32'h3004) $display("FAIL pend_clear got %h exp %h", bus.imemaddr, 32'h3004); else passed++;
        drive(1'b0, 3'd2, 32'h4000);
        tick();
        drive(1'b0, 3'd2, 32'h4800);
        tick();
        drive(1'b1, 3'd0, '0);
        tick();
        total++; if (bus.imemaddr !== 32'h4800) $display("FAIL pend_overwrite got %h exp %h", bus.imemaddr, 32'h4800); else passed++;
        drive(1'b0, 3'd2, 32'h6000);
        tick();
        drive(1'b1, 3'd2, 32'h7000);
        tick();
        total++; if (bus.imemaddr !== 32'h7000) $display("FAIL live_over_pend got %h exp %h", bus.imemaddr, 32'h7000); else passed++;
        drive(1'b1, 3'd0, '0);
        tick();
        total++; if (bus.imemaddr !== 32'h7004) $display("FAIL live_clears_pend got %h exp %h", bus.imemaddr, 32'h7004); else passed++;
    endtask

    task automatic test_wrap();
        drive(1'b1, 3'd2, 32'hFFFF_FFFC);
        tick();
        total++; if (bus.imemaddr !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h exp %h", bus.imemaddr, 32'hFFFF_FFFC); else passed++;
        total++; if (bus.pc_plus4 !== 32'h0) $display("FAIL wrap_pcp4 got %h exp %h", bus.pc_plus4, 32'h0); else passed++;
        drive(1'b1, 3'd0, '0);
        tick();
        total++; if (bus.imemaddr !== 32'h0) $display("FAIL wrap_next got %h exp %h", bus.imemaddr, 32'h0); else passed++;
        tick();
        total++; if (bus.imemaddr !== 32'h4) $display("FAIL wrap_after got %h exp %h", bus.imemaddr, 32'h4); else passed++;
    endtask

    task automatic test_halt();
        // PC = 0x4
        bus.pc_select = 3'd1; bus.ex_pc_plus4 = 32'h1000_0040; bus.ex_jaddr = 26'h10;
        bus.pc_enable = 1'b1; bus.halt_in = 1'b1;
        #1;
        total++; if (bus.halt !== 1'b0) $display("FAIL halt_pre got %b exp 0", bus.halt); else passed++;
        tick();
        total++; if (bus.imemaddr !== 32'h4) $display("FAIL halt_pc got %h exp %h", bus.imemaddr, 32'h4); else passed++;
        total++; if (bus.halt !== 1'b1) $display("FAIL halt_set got %b exp 1", bus.halt); else passed++;
        total++; if (bus.imemREN !== 1'b0) $display("FAIL halt_ren got %b exp 0", bus.imemREN); else passed++;
        bus.halt_in = 1'b0;
        drive(1'b1, 3'd2, 32'h8000);
        tick();
        drive(1'b0, 3'd2, 32'h8800);
        tick();
        drive(1'b1, 3'd0, '0);
        tick();
        total++; if (bus.imemaddr !== 32'h4) $display("FAIL halted_pc got %h exp %h", bus.imemaddr, 32'h4); else passed++;
        total++; if (bus.halt !== 1'b1 || bus.imemREN !== 1'b0) $display("FAIL halted_sticky got halt=%b ren=%b exp halt=1 ren=0", bus.halt, bus.imemREN); else passed++;
    endtask

    task automatic test_reset_midstall();
        #2;
        nRST = 1'b0;
        #1;
        total++; if (bus.halt !== 1'b0 || bus.imemREN !== 1'b1) $display("FAIL rst_unhalt got halt=%b ren=%b exp halt=0 ren=1", bus.halt, bus.imemREN); else passed++;
        @(negedge CLK);
        nRST = 1'b1;
        drive(1'b1, 3'd0, '0);
        tick();
        total++; if (bus.imemaddr !== 32'h4) $display("FAIL rst_run got %h exp %h", bus.imemaddr, 32'h4); else passed++;
        drive(1'b0, 3'd2, 32'h9000);
        tick();
        // Pending is now valid; reset asynchronously in the middle of the cycle
        #2;
        nRST = 1'b0;
        #1;
        total++; if (bus.imemaddr !== 32'h0) $display("FAIL async_rst_pc got %h exp %h", bus.imemaddr, 32'h0); else passed++;
        @(negedge CLK);
        nRST = 1'b1;
        drive(1'b1, 3'd0, '0);
        tick();
        total++; if (bus.imemaddr !== 32'h4) $display("FAIL rst_pend_discard got %h exp %h", bus.imemaddr, 32'h4); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_branch();
        test_jump();
        test_pending();
        test_wrap();
        test_halt();
        test_reset_midstall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
